// File: rtl/vga_console_tty.sv
// vga_console_tty: terminal-style writer feeding a VGA text-console character buffer.
// Accepts bytes over valid/ready, tracks a cursor and a colour attribute,
// interprets control codes, and performs hardware clear and scroll through the
// buffer's write port and combinational read port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    input byte stream (bit 7 ignored)
//   in_ready            high while idle; a byte transfers on in_valid && in_ready
//   wr_en/wr_addr/wr_data  registered buffer write, one cell per cycle
//   rd_addr/rd_data     buffer read used during scroll copy (same-cycle data)
//   cursor_row/col      current cursor position
//   busy                high whenever not idle
module vga_console_tty #(
  parameter int unsigned NUM_ROWS   = 3,
  parameter int unsigned NUM_COLS   = 10,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned ROW_W  = 2;
  localparam int unsigned COL_W  = 4;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(NUM_COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_COPY,
    ST_FILL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              attr;
  logic [6:0]        ch;
  logic [ADDR_W-1:0] cursor_addr;
  logic              printable;
  logic              unused_in_bit7;

  assign ch             = in_data[6:0];
  assign unused_in_bit7 = in_data[7];
  assign printable      = (ch >= 7'h20) && (ch <= 7'h7E);
  assign cursor_addr    = ADDR_W'(ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col));

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Copy source is one row below the destination cell.
  assign rd_addr = (state == ST_COPY) ? ADDR_W'(cnt + COLS_A) : '0;

  // Controller: cell counter shared by clear and scroll (copy then fill continues the count).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      attr       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= BLANK_CHAR;
          if (cnt == LAST_CELL) begin
            cnt        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= ADDR_W'(cnt + ADDR_W'(1));
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= cursor_addr;
              wr_data <= {attr, ch};
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                if (cursor_row == LAST_ROW) begin
                  cnt   <= '0;
                  state <= ST_COPY;
                end else begin
                  cursor_row <= ROW_W'(cursor_row + ROW_W'(1));
                end
              end else begin
                cursor_col <= COL_W'(cursor_col + COL_W'(1));
              end
            end else begin
              case (ch)
                7'h0A: begin
                  cursor_col <= '0;
                  if (cursor_row == LAST_ROW) begin
                    cnt   <= '0;
                    state <= ST_COPY;
                  end else begin
                    cursor_row <= ROW_W'(cursor_row + ROW_W'(1));
                  end
                end
                7'h0D: cursor_col <= '0;
                7'h08: begin
                  if (cursor_col != '0) cursor_col <= COL_W'(cursor_col - COL_W'(1));
                end
                7'h0C: begin
                  cnt   <= '0;
                  state <= ST_CLEAR;
                end
                7'h0E: attr <= 1'b1;
                7'h0F: attr <= 1'b0;
                default: ;
              endcase
            end
          end
        end

        ST_COPY: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= rd_data;
          cnt     <= ADDR_W'(cnt + ADDR_W'(1));
          if (cnt == COPY_LAST) state <= ST_FILL;
        end

        ST_FILL: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= BLANK_CHAR;
          if (cnt == LAST_CELL) begin
            cnt        <= '0;
            cursor_row <= LAST_ROW;
            cursor_col <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= ADDR_W'(cnt + ADDR_W'(1));
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule
